// File: rtl/cpu_param_pkg.sv
// Shared types and sizing helpers for the parametrised CPU datapath.
package cpu_param_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_MUL   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_SHL   = 4'h7,
    OP_SHR   = 4'h8,
    OP_CMP   = 4'h9,
    OP_LOAD  = 4'hA,
    OP_STORE = 4'hB
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    OPND,
    EXEC,
    MEMRD,
    DONE
  } state_e;

  // Operand select width; never below one bit.
  function automatic int sel_w(input int num_in);
    return (num_in < 2) ? 1 : $clog2(num_in);
  endfunction

  // Memory address width; never below one bit.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/cpu_core_param_if.sv
// Command handshake, operand bus and result bus of the CPU core.
interface cpu_core_param_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
);
  import cpu_param_pkg::*;

  localparam int SEL_W = sel_w(NUM_IN);
  localparam int CMD_W = 4 + 2*SEL_W;

  logic                    cmd_valid;
  logic                    cpu_rdy;
  logic [CMD_W-1:0]        cmd_in;
  logic [NUM_IN*WIDTH-1:0] din;
  logic [2*WIDTH-1:0]      out_reg;
  logic                    zero;
  logic                    error;
  logic                    done;

  modport master (
    output cmd_valid, cmd_in, din,
    input  cpu_rdy, out_reg, zero, error, done
  );

  modport slave (
    input  cmd_valid, cmd_in, din,
    output cpu_rdy, out_reg, zero, error, done
  );

endinterface

// File: rtl/cpu_alu_param.sv
// Combinational ALU: operands zero-extended to 2*WIDTH, results wrap.
module cpu_alu_param
  import cpu_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         op,
  output logic [2*WIDTH-1:0] res,
  output logic               illegal
);

  localparam int RW = 2*WIDTH;

  logic [RW-1:0] ax, bx;
  logic          shift_big;

  assign ax        = RW'(a);
  assign bx        = RW'(b);
  assign shift_big = (32'(b) >= RW);

  // NOP/LOAD/STORE results are chosen by the core; they read as zero here.
  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (op)
      OP_NOP, OP_LOAD, OP_STORE: res = '0;
      OP_ADD:  res = ax + bx;
      OP_SUB:  res = ax - bx;
      OP_MUL:  res = ax * bx;
      OP_AND:  res = ax & bx;
      OP_OR:   res = ax | bx;
      OP_XOR:  res = ax ^ bx;
      OP_SHL:  res = shift_big ? '0 : (ax << b);
      OP_SHR:  res = shift_big ? '0 : (ax >> b);
      OP_CMP:  res = (a == b) ? '0 : RW'(1);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_core_param.sv
// CPU core: command FSM, operand select, ALU and result-width memory.
module cpu_core_param
  import cpu_param_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 4,
  parameter int MEM_DEPTH = 16
) (
  input  logic            clk1,
  input  logic            reset1,
  cpu_core_param_if.slave bus
);

  localparam int SEL_W  = sel_w(NUM_IN);
  localparam int ADDR_W = addr_w(MEM_DEPTH);
  localparam int RW     = 2*WIDTH;

  state_e              state_q, state_d;
  logic [3:0]          op_q;
  logic [SEL_W-1:0]    sel_a_q, sel_b_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [RW-1:0]       out_q;
  logic                zero_q, error_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_ok_q;
  logic [RW-1:0]       mem [MEM_DEPTH];

  logic [WIDTH-1:0]    ch [NUM_IN];
  logic [WIDTH-1:0]    opnd_a, opnd_b;
  logic [RW-1:0]       alu_res;
  logic                alu_ill;
  logic                in_range;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_ch
    assign ch[k] = bus.din[k*WIDTH +: WIDTH];
  end

  // Selects outside the channel count read as zero.
  assign opnd_a   = (32'(sel_a_q) < NUM_IN) ? ch[sel_a_q] : '0;
  assign opnd_b   = (32'(sel_b_q) < NUM_IN) ? ch[sel_b_q] : '0;
  assign in_range = (32'(a_q) < MEM_DEPTH);

  assign bus.cpu_rdy = (state_q == IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.out_reg = out_q;
  assign bus.zero    = zero_q;
  assign bus.error   = error_q;

  cpu_alu_param #(.WIDTH(WIDTH)) u_alu (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .res     (alu_res),
    .illegal (alu_ill)
  );

  // State register.
  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: LOAD detours through MEMRD for the synchronous read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = OPND;
      OPND:    state_d = EXEC;
      EXEC:    state_d = (op_q == OP_LOAD) ? MEMRD : DONE;
      MEMRD:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command/operand capture and result registers.
  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      op_q      <= '0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_q     <= '0;
      zero_q    <= 1'b0;
      error_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_ok_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          op_q    <= bus.cmd_in[3:0];
          sel_a_q <= bus.cmd_in[4 +: SEL_W];
          sel_b_q <= bus.cmd_in[4+SEL_W +: SEL_W];
        end
        OPND: begin
          a_q <= opnd_a;
          b_q <= opnd_b;
        end
        EXEC: begin
          if (op_q == OP_NOP) begin
            zero_q  <= (out_q == '0);
            error_q <= 1'b0;
          end else if (op_q == OP_LOAD) begin
            rd_addr_q <= a_q[ADDR_W-1:0];
            rd_ok_q   <= in_range;
          end else if (op_q == OP_STORE) begin
            error_q <= !in_range;
          end else begin
            out_q   <= alu_res;
            zero_q  <= alu_ill | (alu_res == '0);
            error_q <= alu_ill;
          end
        end
        MEMRD: begin
          out_q   <= rd_ok_q ? mem[rd_addr_q] : '0;
          zero_q  <= rd_ok_q ? (mem[rd_addr_q] == '0) : 1'b1;
          error_q <= !rd_ok_q;
        end
        default: ;
      endcase
    end
  end

  // Memory write on the EXEC->DONE edge of an in-range STORE; contents survive reset.
  always_ff @(posedge clk1) begin
    if (!reset1 && state_q == EXEC && op_q == OP_STORE && in_range)
      mem[a_q[ADDR_W-1:0]] <= out_q;
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Self-checking bench for cpu_core_param (WIDTH=8, NUM_IN=4, MEM_DEPTH=16).
module tb_cpu_core_param;

  logic clk1 = 1'b0;
  logic reset1;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] ref_out;
  logic        ref_zero, ref_err;
  logic [15:0] ref_mem [16];

  cpu_core_param_if #(.WIDTH(8), .NUM_IN(4)) bus ();

  cpu_core_param #(.WIDTH(8), .NUM_IN(4), .MEM_DEPTH(16)) dut (
    .clk1   (clk1),
    .reset1 (reset1),
    .bus    (bus)
  );

  always #5 clk1 = ~clk1;

  task automatic set_ch(input int k, input int v);
    bus.din[k*8 +: 8] = v[7:0];
  endtask

  function automatic int get_ch(input int k);
    return int'(bus.din[k*8 +: 8]);
  endfunction

  // Reference behaviour from the opcode table, plain integer arithmetic.
  task automatic model_apply(input int op, input int a, input int b);
    int r;
    r = 0;
    case (op)
      0:  r = int'(ref_out);
      1:  r = a + b;
      2:  r = a - b;
      3:  r = a * b;
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = (b >= 16) ? 0 : (a << b);
      8:  r = (b >= 16) ? 0 : (a >> b);
      9:  r = (a == b) ? 0 : 1;
      10: r = (a < 16) ? int'(ref_mem[a]) : 0;
      default: r = 0;
    endcase
    r = r & 'hFFFF;
    if (op == 11) begin
      if (a < 16) ref_mem[a] = ref_out;
      ref_err = (a >= 16);
    end else if (op >= 12) begin
      ref_out = 16'h0; ref_zero = 1'b1; ref_err = 1'b1;
    end else begin
      ref_out  = r[15:0];
      ref_zero = (r == 0);
      ref_err  = (op == 10 && a >= 16);
    end
  endtask

  // Issue one command, return edges from accept (inclusive) to done; -1 on timeout.
  task automatic run_cmd(input int op, input int sa, input int sb, input bit scramble,
                         output int edges);
    int i;
    logic [3:0] o;
    logic [1:0] a2, b2;
    o = op[3:0]; a2 = sa[1:0]; b2 = sb[1:0];
    @(negedge clk1);
    bus.cmd_in    = {b2, a2, o};
    bus.cmd_valid = 1'b1;
    i = 0;
    while (!bus.cpu_rdy && i < 20) begin @(negedge clk1); i++; end
    if (!bus.cpu_rdy) begin bus.cmd_valid = 1'b0; edges = -1; return; end
    @(posedge clk1);
    #1 bus.cmd_valid = 1'b0;
    edges = 1;
    while (edges < 12) begin
      @(negedge clk1);
      if (bus.done) break;
      if (scramble && edges == 2) bus.din = $urandom;
      @(posedge clk1);
      edges++;
    end
    if (!bus.done) edges = -1;
  endtask

  task automatic test_reset;
    reset1 = 1'b1;
    #1;
    checks++;
    if ({bus.out_reg, bus.zero, bus.error, bus.done, bus.cpu_rdy} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: got out=%h z=%b e=%b d=%b rdy=%b want 0000 0 0 0 1",
               bus.out_reg, bus.zero, bus.error, bus.done, bus.cpu_rdy);
    end
    repeat (2) @(negedge clk1);
    reset1 = 1'b0;
    @(negedge clk1);
    checks++;
    if (bus.cpu_rdy !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b done=%b want 1 0", bus.cpu_rdy, bus.done);
    end
    ref_out = 16'h0; ref_zero = 1'b0; ref_err = 1'b0;
  endtask

  task automatic test_add;
    int e;
    set_ch(0, 200); set_ch(1, 100);
    run_cmd(1, 0, 1, 1'b0, e);
    model_apply(1, 200, 100);
    checks++;
    if (e !== 3) begin failures++; $display("FAIL add_latency: got %0d want 3", e); end
    checks++;
    if ({bus.out_reg, bus.zero, bus.error} !== {16'h012C, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL add_result: got %h z=%b e=%b want 012c 0 0", bus.out_reg, bus.zero, bus.error);
    end
    @(negedge clk1);
    checks++;
    if (bus.done !== 1'b0 || bus.cpu_rdy !== 1'b1) begin
      failures++;
      $display("FAIL add_done_pulse: got done=%b rdy=%b want 0 1", bus.done, bus.cpu_rdy);
    end
  endtask

  task automatic test_sub_cmp;
    int e;
    logic [17:0] want [3];
    int ops [3];
    int sbs [3];
    want[0] = {16'hFFFE, 1'b0, 1'b0}; ops[0] = 2; sbs[0] = 3;
    want[1] = {16'h0000, 1'b1, 1'b0}; ops[1] = 2; sbs[1] = 2;
    want[2] = {16'h0001, 1'b0, 1'b0}; ops[2] = 9; sbs[2] = 3;
    set_ch(2, 5); set_ch(3, 7);
    for (int i = 0; i < 3; i++) begin
      run_cmd(ops[i], 2, sbs[i], 1'b0, e);
      model_apply(ops[i], 5, get_ch(sbs[i]));
      checks++;
      if ({bus.out_reg, bus.zero, bus.error} !== want[i] || e !== 3) begin
        failures++;
        $display("FAIL sub_cmp_%0d: got %h z=%b e=%b edges=%0d want %h edges=3",
                 i, bus.out_reg, bus.zero, bus.error, e, want[i]);
      end
    end
  endtask

  task automatic test_mul_store_load;
    int e;
    set_ch(0, 255); set_ch(1, 255);
    run_cmd(3, 0, 1, 1'b0, e);
    model_apply(3, 255, 255);
    checks++;
    if ({bus.out_reg, bus.zero, bus.error} !== {16'hFE01, 1'b0, 1'b0} || e !== 3) begin
      failures++;
      $display("FAIL mul: got %h z=%b e=%b edges=%0d want fe01 0 0 edges=3",
               bus.out_reg, bus.zero, bus.error, e);
    end
    set_ch(0, 3);
    run_cmd(11, 0, 0, 1'b0, e);
    model_apply(11, 3, 3);
    checks++;
    if ({bus.out_reg, bus.zero, bus.error} !== {16'hFE01, 1'b0, 1'b0} || e !== 3) begin
      failures++;
      $display("FAIL store: got %h z=%b e=%b edges=%0d want fe01 0 0 edges=3",
               bus.out_reg, bus.zero, bus.error, e);
    end
    // Overwrite out_reg first so the LOAD result must come from memory.
    set_ch(1, 1);
    run_cmd(4, 0, 1, 1'b0, e);
    model_apply(4, 3, 1);
    run_cmd(10, 0, 0, 1'b0, e);
    model_apply(10, 3, 3);
    checks++;
    if ({bus.out_reg, bus.zero, bus.error} !== {16'hFE01, 1'b0, 1'b0} || e !== 4) begin
      failures++;
      $display("FAIL load: got %h z=%b e=%b edges=%0d want fe01 0 0 edges=4",
               bus.out_reg, bus.zero, bus.error, e);
    end
  endtask

  task automatic test_errors;
    int e;
    set_ch(0, 20);
    run_cmd(10, 0, 0, 1'b0, e);
    model_apply(10, 20, 20);
    checks++;
    if ({bus.out_reg, bus.error} !== {16'h0, 1'b1} || e !== 4) begin
      failures++;
      $display("FAIL load_oor: got %h e=%b edges=%0d want 0000 1 edges=4", bus.out_reg, bus.error, e);
    end
    set_ch(1, 9); set_ch(2, 4);
    run_cmd(1, 1, 2, 1'b0, e);
    model_apply(1, 9, 4);
    run_cmd(11, 0, 0, 1'b0, e);
    model_apply(11, 20, 20);
    checks++;
    if ({bus.out_reg, bus.zero, bus.error} !== {16'h000D, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL store_oor: got %h z=%b e=%b want 000d 0 1", bus.out_reg, bus.zero, bus.error);
    end
    run_cmd(13, 1, 2, 1'b0, e);
    model_apply(13, 9, 4);
    checks++;
    if ({bus.out_reg, bus.zero, bus.error} !== {16'h0, 1'b1, 1'b1} || e !== 3) begin
      failures++;
      $display("FAIL illegal_op: got %h z=%b e=%b edges=%0d want 0000 1 1 edges=3",
               bus.out_reg, bus.zero, bus.error, e);
    end
  endtask

  task automatic test_reset_abort;
    int e;
    int dn;
    set_ch(2, 3); set_ch(3, 4);
    run_cmd(1, 2, 3, 1'b0, e);
    model_apply(1, 3, 4);
    checks++;
    if (bus.out_reg !== 16'h0007) begin
      failures++;
      $display("FAIL abort_setup: got %h want 0007", bus.out_reg);
    end
    set_ch(2, 50); set_ch(3, 60);
    @(negedge clk1);
    bus.cmd_in = {2'd3, 2'd2, 4'd1}; bus.cmd_valid = 1'b1;
    @(posedge clk1);
    #1 bus.cmd_valid = 1'b0;
    @(posedge clk1);
    #2 reset1 = 1'b1;
    #1;
    checks++;
    if ({bus.out_reg, bus.zero, bus.error, bus.done, bus.cpu_rdy} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL abort_reset: got out=%h z=%b e=%b d=%b rdy=%b want 0000 0 0 0 1",
               bus.out_reg, bus.zero, bus.error, bus.done, bus.cpu_rdy);
    end
    @(negedge clk1);
    reset1 = 1'b0;
    ref_out = 16'h0; ref_zero = 1'b0; ref_err = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk1);
      if (bus.done) dn++;
    end
    checks++;
    if (dn !== 0 || bus.out_reg !== 16'h0) begin
      failures++;
      $display("FAIL abort_no_done: got done_pulses=%0d out=%h want 0 0000", dn, bus.out_reg);
    end
  endtask

  task automatic test_back_to_back;
    int acc_t [3];
    int acc, cyc, busy, dn, w;
    logic rdy;
    set_ch(0, 10); set_ch(1, 20);
    acc = 0; cyc = 0; busy = 0; dn = 0;
    @(negedge clk1);
    bus.cmd_in = {2'd1, 2'd0, 4'd1}; bus.cmd_valid = 1'b1;
    while (acc < 3 && cyc < 40) begin
      if (cyc > 0) @(negedge clk1);
      rdy = bus.cpu_rdy;
      if (!rdy) busy++;
      if (bus.done) dn++;
      @(posedge clk1);
      if (rdy) begin acc_t[acc] = cyc; acc++; end
      cyc++;
    end
    #1 bus.cmd_valid = 1'b0;
    w = 0;
    while (w < 10) begin
      @(negedge clk1);
      if (bus.done) begin dn++; break; end
      w++;
    end
    model_apply(1, 10, 20);
    checks++;
    if (acc !== 3) begin failures++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
    checks++;
    if (acc == 3 && (acc_t[1] - acc_t[0] !== 4 || acc_t[2] - acc_t[1] !== 4)) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d %0d want 4 4", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
    end
    checks++;
    if (busy !== 6 || dn !== 3) begin
      failures++;
      $display("FAIL b2b_busy: got busy=%0d done=%0d want 6 3", busy, dn);
    end
    checks++;
    if ({bus.out_reg, bus.zero, bus.error} !== {16'd30, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_result: got %h z=%b e=%b want 001e 0 0", bus.out_reg, bus.zero, bus.error);
    end
    @(negedge clk1);
    checks++;
    if (bus.cpu_rdy !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got rdy=%b done=%b want 1 0", bus.cpu_rdy, bus.done);
    end
  endtask

  // Give every memory word a known value via random ADD then STORE.
  task automatic test_mem_fill;
    int e;
    for (int ad = 0; ad < 16; ad++) begin
      bus.din = $urandom;
      run_cmd(1, 1, 2, 1'b0, e);
      model_apply(1, get_ch(1), get_ch(2));
      set_ch(0, ad);
      run_cmd(11, 0, 3, 1'b0, e);
      model_apply(11, ad, get_ch(3));
      checks++;
      if ({bus.out_reg, bus.zero, bus.error} !== {ref_out, ref_zero, ref_err} || e !== 3) begin
        failures++;
        $display("FAIL fill_%0d: got %h z=%b e=%b edges=%0d want %h %b %b edges=3",
                 ad, bus.out_reg, bus.zero, bus.error, e, ref_out, ref_zero, ref_err);
      end
    end
  endtask

  task automatic test_random;
    int e, op, sa, sb, a, b, want_e;
    for (int n = 0; n < 80; n++) begin
      bus.din = $urandom;
      op = $urandom_range(0, 15);
      sa = $urandom_range(0, 3);
      sb = $urandom_range(0, 3);
      if (op == 10 || op == 11) set_ch(sa, $urandom_range(0, 20));
      if ((op == 7 || op == 8) && sa != sb) set_ch(sb, $urandom_range(0, 20));
      a = get_ch(sa);
      b = get_ch(sb);
      run_cmd(op, sa, sb, 1'b1, e);
      model_apply(op, a, b);
      want_e = (op == 10) ? 4 : 3;
      checks++;
      if ({bus.out_reg, bus.zero, bus.error} !== {ref_out, ref_zero, ref_err} || e !== want_e) begin
        failures++;
        $display("FAIL rand_%0d op=%0d a=%0d b=%0d: got %h z=%b e=%b edges=%0d want %h %b %b edges=%0d",
                 n, op, a, b, bus.out_reg, bus.zero, bus.error, e, ref_out, ref_zero, ref_err, want_e);
      end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_in    = '0;
    bus.din       = '0;
    test_reset;
    test_add;
    test_sub_cmp;
    test_mul_store_load;
    test_errors;
    test_reset_abort;
    test_back_to_back;
    test_mem_fill;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
Parametrised successor to the fixed 4-input, 8-bit CPU datapath. Selects two operands from NUM_IN input channels and runs ALU, load and store operations against an internal result-width memory. Commands enter through a valid/ready handshake. A multi-state control FSM sequences each command and pulses done when the registered result is valid. Sits as the top compute block, fed by upstream data registers and a command source.

Parameters:
WIDTH, 8, operand width; result, memory word and out_reg are 2*WIDTH
NUM_IN, 4, number of data input channels (>=2); SEL_W = $clog2(NUM_IN)
MEM_DEPTH, 16, memory words; ADDR_W = $clog2(MEM_DEPTH)

Ports:
clk1  in  1  single clock; all state on rising edge
reset1  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cpu_rdy  out  1  ready; high only in IDLE; a command is accepted on an edge with cmd_valid & cpu_rdy
cmd_in  in  4+2*SEL_W  [3:0] opcode, [4+:SEL_W] sel_a, [4+SEL_W+:SEL_W] sel_b
din  in  NUM_IN*WIDTH  packed channels; channel k = din[k*WIDTH+:WIDTH]
out_reg  out  2*WIDTH  registered result
zero  out  1  registered: result == 0
error  out  1  registered: illegal opcode or address out of range
done  out  1  one-cycle pulse when out_reg/zero/error are updated

Behaviour:
- Reset (async, any state): FSM->IDLE; out_reg=0, zero=0, error=0, done=0; cpu_rdy=1 once reset deasserts. Memory contents are not reset. Reset mid-command aborts it with no memory write.
- FSM: IDLE -> OPND (accept edge: latch cmd_in) -> EXEC (latch A=din[sel_a], B=din[sel_b]) -> DONE (ALU/STORE/illegal) or MEMRD (LOAD) -> DONE -> IDLE.
- done=1 exactly in the DONE state.
- ALU latency: done high in the cycle after the 3rd edge counted from the accept edge. LOAD takes one extra cycle (4th edge).
- Operands are sampled at the OPND->EXEC edge. din changes after that edge do not affect the command.
- cmd_valid while busy is ignored (cpu_rdy=0). There is no queueing; the source holds cmd_valid until it is accepted.
- Opcodes; operands zero-extended to 2*WIDTH, results modulo 2^(2*WIDTH):
  - 0 NOP: result = current out_reg.
  - 1 ADD, 2 SUB (wraps, e.g. 5-7 = all-ones minus 1), 3 MUL (full 2*WIDTH product), 4 AND, 5 OR, 6 XOR.
  - 7 SHL: A<<B; 8 SHR: A>>B; any shift amount >= 2*WIDTH gives 0.
  - 9 CMP: result = (A==B) ? 0 : 1.
  - A LOAD: result = mem[A].
  - B STORE: mem[A] <= out_reg, written on the EXEC->DONE edge; out_reg and zero unchanged; error=0.
  - C-F illegal: out_reg <= 0, zero <= 1, error <= 1, no memory access.
- Memory address: if A >= MEM_DEPTH, LOAD returns result 0 with error=1, and STORE does not write and sets error=1.
- Memory is synchronous read: address registered in EXEC, data captured at MEMRD->DONE.
- zero and error are updated together with out_reg at the edge entering DONE. For all legal, in-range ops error=0, and zero=(result==0) except STORE.

Decomposition:
- Package cpu_param_pkg:
  - opcode enum op_e (OP_NOP..OP_STORE).
  - FSM state enum state_e (IDLE, OPND, EXEC, MEMRD, DONE).
  - localparam functions for SEL_W and ADDR_W.
- One sub-module cpu_alu_param: combinational, parameter WIDTH; inputs a, b, op; outputs res[2*WIDTH-1:0] and illegal.
- Memory array, operand muxing and the FSM stay in cpu_core_param.

Test Plan (WIDTH=8, NUM_IN=4, MEM_DEPTH=16):
1. Reset pulse mid-EXEC of an ADD -> out_reg=0, zero=0, error=0, done=0, cpu_rdy=1 immediately; no done pulse for the aborted ADD.
2. din0=200, din1=100, ADD sel_a=0 sel_b=1 -> done on 3rd edge after accept, out_reg=0x012C, zero=0, error=0.
3. din2=5, din3=7: SUB 2,3 -> 0xFFFE; SUB 2,2 -> 0x0000 with zero=1; CMP 2,3 -> 0x0001.
4. din0=din1=255, MUL -> 0xFE01. Then din0=3, STORE sel_a=0 -> mem[3]=0xFE01, out_reg remains 0xFE01. Then LOAD sel_a=0 -> 0xFE01 with done on the 4th edge.
5. din0=20: LOAD -> out_reg=0, error=1. Opcode 0xD -> out_reg=0, zero=1, error=1.
6. cmd_valid held high across 3 back-to-back ADDs -> exactly 3 accepts, each separated by 4 cycles, with cpu_rdy low during each busy period.
